// File: rtl/alu_cmd_driver_pkg.sv
// Shared types and helpers for the ALU command driver.
// Holds the FSM state encoding, ALU op codes and result masking.
package alu_cmd_driver_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARST  = 3'd1,
    S_START = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4,
    S_RESP  = 3'd5
  } drv_state_e;

  // add/sub are 8-bit results: carry/borrow in the upper byte is dropped.
  function automatic logic [15:0] mask_result(input logic [1:0] op, input logic [15:0] outbus);
    logic [15:0] res;
    case (op)
      OP_ADD, OP_SUB: res = {8'h00, outbus[7:0]};
      default:        res = outbus;
    endcase
    return res;
  endfunction

  // First word placed on the ALU input bus: divide takes the full 16-bit dividend.
  function automatic logic [15:0] first_operand(input logic [1:0] op, input logic [15:0] a);
    logic [15:0] res;
    if (op == OP_DIV) begin
      res = a;
    end else begin
      res = {8'h00, a[7:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_cmd_driver_drv_timer.sv
// Clearable saturating up-counter with a terminal flag.
// Used by alu_cmd_driver to bound the wait for the ALU finish flag.
module drv_timer #(
  parameter int MAX = 63
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam int W = $clog2(MAX + 2);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, then count up and saturate at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (en_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == MAX_V);

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for the ALU start/sel/inbus/outbus/finish protocol.
// One request in flight: reset ALU, load operands in order, wait finish, return result.
// Optional macro ALU_DRV_TIMEOUT_EN adds a WAIT timeout that returns rsp_err=1.
module alu_cmd_driver
  import alu_cmd_driver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RST_CYCLES     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [7:0]  req_m,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        alu_rst,
  output logic        alu_start,
  output logic [1:0]  alu_sel,
  output logic [15:0] alu_inbus,
  input  logic [15:0] alu_outbus,
  input  logic        alu_finish
);

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

  drv_state_e  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  m_q, m_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        busy_q, busy_d;
  logic        alu_rst_q, alu_rst_d;
  logic        alu_start_q, alu_start_d;
  logic [1:0]  alu_sel_q, alu_sel_d;
  logic [15:0] alu_inbus_q, alu_inbus_d;

`ifdef ALU_DRV_TIMEOUT_EN
  logic tmo_hit_s;

  // Counter is held clear outside WAIT, so it restarts from zero on each entry.
  drv_timer #(
    .MAX (TIMEOUT_CYCLES - 1)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q != S_WAIT),
    .en_i   (state_q == S_WAIT),
    .term_o (tmo_hit_s)
  );
`endif

  // Next state, operand latch, result capture and next registered outputs.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    m_d        = m_q;
    rcnt_d     = rcnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d    = req_op;
          a_d     = req_a;
          m_d     = req_m;
          rcnt_d  = 8'd0;
          state_d = S_ARST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARST: begin
        if (rcnt_q == RST_LAST) begin
          state_d = S_START;
        end else begin
          rcnt_d = rcnt_q + 8'd1;
        end
      end
      S_START: state_d = S_HOLD;
      S_HOLD:  state_d = S_WAIT;
      S_WAIT: begin
        // finish takes priority over a timeout on the same cycle
        if (alu_finish) begin
          rsp_data_d = mask_result(op_q, alu_outbus);
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
`ifdef ALU_DRV_TIMEOUT_EN
        end else if (tmo_hit_s) begin
          rsp_data_d = 16'h0000;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
`endif
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the state being entered so they are registered alongside it.
    alu_sel_d   = alu_sel_q;
    alu_inbus_d = alu_inbus_q;
    case (state_d)
      S_START, S_HOLD: begin
        alu_sel_d   = op_d;
        alu_inbus_d = first_operand(op_d, a_d);
      end
      S_WAIT: begin
        alu_sel_d   = op_q;
        alu_inbus_d = {8'h00, m_q};
      end
      S_RESP: begin
        alu_sel_d   = alu_sel_q;
        alu_inbus_d = alu_inbus_q;
      end
      default: begin
        alu_sel_d   = 2'b00;
        alu_inbus_d = 16'h0000;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    alu_rst_d   = (state_d == S_ARST);
    alu_start_d = (state_d == S_START);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State, operand and output registers; the ALU is held in reset while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      a_q         <= 16'h0000;
      m_q         <= 8'h00;
      rcnt_q      <= 8'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      alu_rst_q   <= 1'b1;
      alu_start_q <= 1'b0;
      alu_sel_q   <= 2'b00;
      alu_inbus_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      m_q         <= m_d;
      rcnt_q      <= rcnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      alu_rst_q   <= alu_rst_d;
      alu_start_q <= alu_start_d;
      alu_sel_q   <= alu_sel_d;
      alu_inbus_q <= alu_inbus_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign alu_rst   = alu_rst_q;
  assign alu_start = alu_start_q;
  assign alu_sel   = alu_sel_q;
  assign alu_inbus = alu_inbus_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver paired with a small behavioural ALU stub.
// The stub takes the first operand at start, the second two cycles later, and raises
// finish after a programmable delay (or never, when stuck).
module tb_alu_cmd_driver;

  localparam int TB_RST = 2;
  localparam int TB_TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_a = 16'h0000;
  logic [7:0]  req_m = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        alu_rst;
  logic        alu_start;
  logic [1:0]  alu_sel;
  logic [15:0] alu_inbus;
  logic [15:0] alu_outbus = 16'h0000;
  logic        alu_finish = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  alu_cmd_driver #(
    .TIMEOUT_CYCLES (TB_TMO),
    .RST_CYCLES     (TB_RST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_m      (req_m),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .alu_rst    (alu_rst),
    .alu_start  (alu_start),
    .alu_sel    (alu_sel),
    .alu_inbus  (alu_inbus),
    .alu_outbus (alu_outbus),
    .alu_finish (alu_finish)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural ALU stub ----------------
  logic        stub_stuck = 1'b0;
  int          stub_lat = 0;
  int          ph = 0;
  int          wcnt = 0;
  logic [15:0] s_a = 16'h0000;
  logic [1:0]  s_sel = 2'b00;
  logic [15:0] s_res = 16'h0000;

  function automatic logic [15:0] alu_calc(input logic [1:0] sel, input logic [15:0] a, input logic [7:0] m);
    logic [15:0] r;
    case (sel)
      2'b00: r = {8'h00, a[7:0]} + {8'h00, m};
      2'b01: r = {8'h00, a[7:0]} - {8'h00, m};
      2'b10: r = a[7:0] * m;
      default: begin
        if (m == 8'h00) r = 16'hFFFF;
        else begin
          r[15:8] = 8'(a % {8'h00, m});
          r[7:0]  = 8'(a / {8'h00, m});
        end
      end
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (alu_rst) begin
      alu_finish <= 1'b0;
      ph <= 0;
    end else if (alu_start) begin
      s_a <= alu_inbus;
      s_sel <= alu_sel;
      ph <= 1;
    end else if (ph == 1) begin
      ph <= 2;
    end else if (ph == 2) begin
      s_res <= alu_calc(s_sel, s_a, alu_inbus[7:0]);
      wcnt <= 0;
      ph <= 3;
    end else if (ph == 3 && !stub_stuck) begin
      if (wcnt >= stub_lat) begin
        alu_outbus <= s_res;
        alu_finish <= 1'b1;
        ph <= 4;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [7:0] m,
                        input logic [15:0] exp_data, input int lat, input int stall);
    int rst_cyc = 0;
    int start_cyc = 0;
    int sidx = -10;
    int busy_bad = 0;
    int ridx = -1;
    int unstable = 0;
    logic [15:0] s_inb = 16'h0;
    logic [15:0] h_inb = 16'h0;
    logic [15:0] w_inb = 16'h0;
    logic [1:0]  st_sel = 2'b00;
    logic [1:0]  w_sel = 2'b00;
    logic        h_start = 1'b1;
    logic [15:0] exp_first;
    exp_first = (op == 2'b11) ? a : {8'h00, a[7:0]};
    stub_lat = lat;
    stub_stuck = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_m = m;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin
        ridx = i;
        break;
      end
      if (alu_rst) rst_cyc++;
      if (alu_start) begin
        start_cyc++;
        s_inb = alu_inbus;
        st_sel = alu_sel;
        sidx = i;
      end
      if (i == sidx + 1) begin
        h_inb = alu_inbus;
        h_start = alu_start;
      end
      if (i == sidx + 2) begin
        w_inb = alu_inbus;
        w_sel = alu_sel;
      end
      if (!busy || req_ready) busy_bad++;
      @(negedge clk);
    end
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("latency", ridx, TB_RST + 5 + lat);
    check("rsp_data", {16'd0, rsp_data}, {16'd0, exp_data});
    check("rsp_err", {31'd0, rsp_err}, 32'd0);
    check("alu_rst_cycles", rst_cyc, TB_RST);
    check("start_cycles", start_cyc, 1);
    check("start_inbus", {16'd0, s_inb}, {16'd0, exp_first});
    check("start_sel", {30'd0, st_sel}, {30'd0, op});
    check("hold_inbus", {16'd0, h_inb}, {16'd0, exp_first});
    check("hold_start", {31'd0, h_start}, 32'd0);
    check("wait_inbus", {16'd0, w_inb}, {16'd0, 8'h00, m});
    check("wait_sel", {30'd0, w_sel}, {30'd0, op});
    check("busy_during_op", busy_bad, 0);
    if (stall > 0) begin
      req_valid = 1'b1; req_op = 2'b00; req_a = 16'h0001; req_m = 8'h01;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_data !== exp_data || req_ready || !busy) unstable++;
      end
      check("rsp_stall_stable", unstable, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_dropped", {31'd0, rsp_valid}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_ready", {31'd0, req_ready}, 32'd1);
    check("idle_inbus", {16'd0, alu_inbus}, 32'd0);
  endtask

  initial begin
    int seen;
    int ridx;
    rst_n = 1'b0;
    #12;
    check("rst_alu_rst", {31'd0, alu_rst}, 32'd1);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_start", {31'd0, alu_start}, 32'd0);
    check("rst_inbus", {16'd0, alu_inbus}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_alu_rst", {31'd0, alu_rst}, 32'd0);

    run_op(2'b00, 16'd40,    8'd12,  16'd52,   0, 0);
    run_op(2'b01, 16'd40,    8'd12,  16'd28,   3, 0);
    run_op(2'b10, 16'd40,    8'd12,  16'h01E0, 1, 10);
    run_op(2'b11, 16'd11542, 8'd135, 16'h4355, 5, 0);
    run_op(2'b00, 16'hAB28,  8'd12,  16'd52,   0, 0);
    run_op(2'b00, 16'd200,   8'd100, 16'h002C, 2, 0);
    run_op(2'b01, 16'd12,    8'd40,  16'h00E4, 0, 3);
    run_op(2'b10, 16'd255,   8'd255, 16'hFE01, 4, 0);

    // finish never arrives
    stub_stuck = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_a = 16'd7; req_m = 8'd9;
    @(negedge clk);
    req_valid = 1'b0;
`ifdef ALU_DRV_TIMEOUT_EN
    ridx = -1;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin
        ridx = i;
        break;
      end
      @(negedge clk);
    end
    check("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("tmo_latency", ridx, TB_RST + 2 + TB_TMO);
    check("tmo_err", {31'd0, rsp_err}, 32'd1);
    check("tmo_data", {16'd0, rsp_data}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("tmo_rsp_dropped", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_a = 16'd7; req_m = 8'd9;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
`else
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    check("stuck_no_rsp", seen, 0);
    check("stuck_wait_inbus", {16'd0, alu_inbus}, {16'd0, 16'd9});
`endif
    // reset pulsed while waiting for finish
    check("wait_busy", {31'd0, busy}, 32'd1);
    check("wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_alu_rst", {31'd0, alu_rst}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_start", {31'd0, alu_start}, 32'd0);
    check("midrst_sel", {30'd0, alu_sel}, 32'd0);
    check("midrst_inbus", {16'd0, alu_inbus}, 32'd0);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("after_rst_no_rsp", seen, 0);
    check("after_rst_ready", {31'd0, req_ready}, 32'd1);
    check("after_rst_alu_rst", {31'd0, alu_rst}, 32'd0);

    // driver still usable after an abandoned op
    run_op(2'b00, 16'd40, 8'd12, 16'd52, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
